// File: rtl/onehot_enc_tx.sv
// onehot_enc_tx: buffers binary indices in a 2-entry FIFO and presents the head as a one-hot code.
// Ports:
//   clk       - rising-edge clock
//   rst_n     - asynchronous active-low reset
//   in_valid  - producer offers in_idx
//   in_idx    - binary index to encode (IDX_W bits)
//   in_ready  - FIFO has room (count < 2), registered
//   out_valid - FIFO not empty
//   out_code  - one-hot of FIFO head, zero when out_valid is low
//   out_ready - downstream accepts out_code
//   sent_cnt  - wrapping count of completed output transfers
//   idle      - FIFO empty
module onehot_enc_tx #(
    parameter int IDX_W = 3,
    localparam int CODE_W = 2 ** IDX_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [IDX_W-1:0]  in_idx,
    output logic              in_ready,
    output logic              out_valid,
    output logic [CODE_W-1:0] out_code,
    input  logic              out_ready,
    output logic [7:0]        sent_cnt,
    output logic              idle
);
    logic [IDX_W-1:0] mem [2];
    logic             wptr;
    logic             rptr;
    logic [1:0]       count;
    logic             push;
    logic             pop;

    // in_ready depends only on count, so a full FIFO refuses a push even when
    // it is popped in the same cycle; this keeps out_ready off the input path.
    always_comb begin
        in_ready  = count < 2'd2;
        out_valid = count != 2'd0;
        idle      = count == 2'd0;
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
        out_code  = out_valid ? CODE_W'(1) << mem[rptr] : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem      <= '{default: '0};
            wptr     <= 1'b0;
            rptr     <= 1'b0;
            count    <= 2'd0;
            sent_cnt <= 8'd0;
        end else begin
            if (push) begin
                mem[wptr] <= in_idx;
                wptr      <= ~wptr;
            end
            if (pop) begin
                rptr     <= ~rptr;
                sent_cnt <= sent_cnt + 8'd1;
            end
            count <= count + 2'(push) - 2'(pop);
        end
    end
endmodule

// File: doc/onehot_enc_tx.md
ONEHOT_ENC_TX -- requirements
Module: onehot_enc_tx

Interface
REQ-001 The block SHALL have parameter IDX_W, default 3, meaning index width in bits.
REQ-002 The block SHALL have derived parameter CODE_W = 2**IDX_W, meaning one-hot code width (8 at default).
REQ-003 The block SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 The block SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port in_valid  input  1  producer offers in_idx this cycle.
REQ-006 The block SHALL have port in_idx  input  IDX_W  binary index to encode.
REQ-007 The block SHALL have port in_ready  output  1  block can accept an index this cycle.
REQ-008 The block SHALL have port out_valid  output  1  out_code holds a valid one-hot word.
REQ-009 The block SHALL have port out_code  output  CODE_W  one-hot code, bit in_idx set.
REQ-010 The block SHALL have port out_ready  input  1  downstream one-hot checker accepts out_code.
REQ-011 The block SHALL have port sent_cnt  output  8  count of completed output transfers.
REQ-012 The block SHALL have port idle  output  1  buffer empty, no transfer pending.

Function
REQ-013 An input transfer SHALL occur on a rising edge where in_valid and in_ready are both 1.
REQ-014 An output transfer SHALL occur on a rising edge where out_valid and out_ready are both 1.
REQ-015 Accepted indices SHALL be stored in a 2-entry FIFO (write pointer, read pointer, 2-bit occupancy count 0..2).
REQ-016 in_ready SHALL be 1 exactly when count < 2, driven from registers only, with no combinational path from out_ready.
REQ-017 out_valid SHALL be 1 exactly when count != 0.
REQ-018 out_code SHALL equal 1 << (FIFO head index) when out_valid = 1, and SHALL be all zeros when out_valid = 0.
REQ-019 out_code SHALL have exactly one bit set whenever out_valid = 1.
REQ-020 Latency SHALL be one cycle: an index accepted at edge k appears on out_code after edge k when the FIFO was empty.
REQ-021 Indices SHALL leave in acceptance order, with no loss or duplication.
REQ-022 A simultaneous push and pop with count = 1 SHALL leave count at 1 and advance both pointers.
REQ-023 A simultaneous push and pop with count = 0 SHALL NOT occur, because out_valid = 0.
REQ-024 When count = 2, push SHALL be blocked even if a pop happens in the same cycle, and count SHALL become 1.
REQ-025 out_code and out_valid SHALL hold stable while out_valid = 1 and out_ready = 0.
REQ-026 sent_cnt SHALL increment by 1 on each output transfer and SHALL wrap from 255 to 0.
REQ-027 idle SHALL be 1 exactly when count = 0.
REQ-028 in_idx SHALL be ignored when no input transfer occurs.
REQ-029 All in_idx values 0..CODE_W-1 SHALL be legal.

Reset
REQ-030 Asserting rst_n = 0 SHALL immediately, without waiting for clk, clear count, pointers and sent_cnt.
REQ-031 After reset, outputs SHALL be in_ready = 1, out_valid = 0, out_code = 0, sent_cnt = 0, idle = 1.
REQ-032 A reset asserted mid-operation SHALL discard FIFO contents, and no stale code SHALL appear after release.
REQ-033 After rst_n deasserts, the first rising edge SHALL be able to accept an input.

Verification
REQ-034 Reset check: after reset, outputs SHALL be in_ready = 1, out_valid = 0, out_code = 8'h00, sent_cnt = 0, idle = 1.
REQ-035 Single transfer: push in_idx = 5 with out_ready = 1 -> next cycle out_code = 8'b0010_0000, out_valid = 1; after the transfer sent_cnt = 1, idle = 1.
REQ-036 Backpressure: out_ready = 0, push 2 then 7 -> in_ready = 0, out_code held at 8'h04; set out_ready = 1 -> outputs 8'h04 then 8'h80 in order.
REQ-037 Streaming: in_valid = 1 and out_ready = 1 continuously over indices 0..7 -> outputs 8'h01..8'h80 in order, one per cycle, count never exceeds 1.
REQ-038 Wrap: complete 256 transfers -> sent_cnt = 0; transfer 257 -> sent_cnt = 1.
REQ-039 Mid-operation reset: with FIFO full, pulse rst_n low between clock edges -> immediately out_valid = 0, out_code = 0, in_ready = 1; no old code appears after release.
